stop_watch_gen: RTL
===================

// Module: stop_watch_gen
// PURPOSE
//  Parametrised successor stopwatch core: MM:SS counter (00:00-99:59) with pause, adjust,
//  count-up/count-down mode and a 4-digit multiplexed active-low 7-segment driver.
//  All rates are derived from CLK_HZ by parameters, so benches can shrink them.
//  Sits between the debounced board buttons/switches and the display pins; single clock domain.
// PARAMETERS
//  CLK_HZ   100_000_000  input clock frequency
//  TICK_HZ  1            count rate in normal mode (1 = one second per count)
//  ADJ_HZ   2            field increment rate in adjust mode
//  SCAN_HZ  500          digit-scan rate; each digit is active for CLK_HZ/SCAN_HZ cycles
//  MAX_MIN  99           highest minutes value, 1..99
// PORTS
//  clk_100mhz in  1  system clock
//  rst        in  1  synchronous active-high reset
//  pause      in  1  debounced, synchronous; a rising edge toggles run/paused
//  sw1        in  1  1 = adjust mode
//  sw2        in  1  adjust field select: 0 = minutes, 1 = seconds
//  dir        in  1  0 = count up, 1 = count down
//  lap        in  1  rising edge toggles lap freeze (STOP_WATCH_LAP_EN only)
//  seg        out 7  {CA,CB,CC,CD,CE,CF,CG}, active-low
//  an         out 4  {AN3,AN2,AN1,AN0}, active-low; AN0 = seconds ones, AN3 = minutes tens
//  running    out 1  1 when not paused, not in adjust mode and not done
//  done       out 1  1 while held at 00:00 in count-down mode
// BEHAVIOUR
//  - rst is synchronous and active-high, sampled on posedge clk_100mhz, and dominates all inputs.
//  - Reset state: time 00:00, run state, all dividers 0, lap off.
//  - Reset outputs: an = 4'b1110, seg = 7'b0000001 ("0"), running = 1, done = 0.
//  - Dividers: tick_cnt counts 0..CLK_HZ/TICK_HZ-1 and pulses tick at the terminal count.
//    adj_cnt and scan_cnt work the same way with ADJ_HZ and SCAN_HZ. Each width is $clog2(ratio).
//  - Edge detect: pause and lap are registered once; an edge is reg==0 && input==1. Latency is 1 clock.
//  - State machine (RUN, PAUSED, ADJUST):
//    * RUN <-> PAUSED on a pause edge.
//    * Any state -> ADJUST while sw1 = 1; pause edges are ignored in ADJUST.
//    * When sw1 falls, return to the state held before ADJUST.
//  - RUN, dir = 0: on tick, sec+1. At sec 59 -> sec 0, min+1. At MAX_MIN:59 -> wrap to 00:00.
//  - RUN, dir = 1: on tick, sec-1. At sec 0 -> sec 59, min-1. At 00:00 -> hold and set done = 1.
//    done clears on any time change, on dir = 0, or on rst.
//  - ADJUST: on the adj tick, increment only the selected field, with no carry.
//    sec wraps 59->0; min wraps MAX_MIN->0. tick_cnt is held at 0 in ADJUST and PAUSED.
//  - Digits are binary-coded decimal (BCD) counters (sec_o 0-9, sec_t 0-5, min_o, min_t), not binary plus divide.
//  - Scan: on each scan pulse, digit index advances 0->1->2->3->0.
//    an is one-hot-low on the index; seg is the decoded BCD of that digit, same cycle.
//  - Segment codes: 0 = 7'b0000001, 1 = 7'b1001111, 8 = 7'b0000000. Codes 10-15 give all segments off.
//  - Simultaneous events: rst > sw1 > pause edge. A tick coinciding with a pause edge is still counted.
// CONFIGURATION
//  STOP_WATCH_LAP_EN defined:
//    - A lap edge toggles the freeze. On entry, the displayed value is latched into a shadow register.
//    - Counting continues underneath. The display shows the shadow until the next lap edge or rst.
//  STOP_WATCH_LAP_EN undefined:
//    - The lap port exists but is ignored; the display always shows the live count.
// TESTING  (CLK_HZ=1000, TICK_HZ=10, ADJ_HZ=20, SCAN_HZ=250 -> tick every 100 clk, scan every 4)
//  1. Release rst, dir=0, run 6000 clk -> time 01:00; an walks 1110,1101,1011,0111 every 4 clk.
//  2. Pause edge at 00:03, wait 1000 clk -> still 00:03, running=0.
//     Second pause edge, wait 100 clk -> 00:04.
//  3. Preload 99:59 via adjust, run one tick -> 00:00, done=0.
//  4. dir=1 from 00:02, run 300 clk -> 00:00, done=1 held.
//     Set dir=0 -> done=0; next tick gives 00:01.
//  5. sw1=1, sw2=1 at 00:58 for 150 clk -> 3 adj ticks -> 00:01, minutes unchanged.
//     Assert rst mid-adjust -> 00:00, an=1110.
//  6. LAP_EN: lap edge at 00:05, run 200 clk -> display 00:05, internal 00:07.
//     Next lap edge -> display 00:07.

Source files
------------

// File: rtl/stop_watch_gen_if.sv
// Bundle of stopwatch controls (switches/buttons) and display outputs.
// The stopwatch core connects to the slave modport; whatever drives the buttons uses master.
interface stop_watch_gen_if;
    logic       pause;
    logic       sw1;
    logic       sw2;
    logic       dir;
    logic       lap;
    logic [6:0] seg;
    logic [3:0] an;
    logic       running;
    logic       done;

    modport master (
        output pause, sw1, sw2, dir, lap,
        input  seg, an, running, done
    );

    modport slave (
        input  pause, sw1, sw2, dir, lap,
        output seg, an, running, done
    );
endinterface

// File: rtl/stop_watch_gen.sv
// MM:SS BCD stopwatch with pause, adjust, up/down count and a 4-digit multiplexed 7-seg driver.
// Define STOP_WATCH_LAP_EN to enable the lap-freeze display shadow.
module stop_watch_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int ADJ_HZ  = 2,
    parameter int SCAN_HZ = 500,
    parameter int MAX_MIN = 99
) (
    input  logic            clk_100mhz,
    input  logic            rst,
    stop_watch_gen_if.slave bus
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int ADJ_DIV  = CLK_HZ / ADJ_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ADJ_W    = (ADJ_DIV  > 1) ? $clog2(ADJ_DIV)  : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADJ_W-1:0]  ADJ_LAST  = ADJ_W'(ADJ_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {S_RUN, S_PAUSED, S_ADJUST} state_t;

    state_t r_state, w_state_nxt;
    state_t r_ret,   w_ret_nxt;

    logic              r_pause_d;
    logic              w_pause_edge;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [ADJ_W-1:0]  r_adj_cnt;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic              w_tick, w_adj_tick, w_scan_tick;
    logic [1:0]        r_dig_idx;
    logic [3:0]        r_sec_o, r_sec_t, r_min_o, r_min_t;
    logic              r_done;
    logic              w_zero, w_min_max, w_sec_max;
    logic [15:0]       w_live, w_disp;
    logic [3:0]        w_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign w_pause_edge = bus.pause & ~r_pause_d;
    assign w_tick       = (r_state == S_RUN)    && (r_tick_cnt == TICK_LAST);
    assign w_adj_tick   = (r_state == S_ADJUST) && (r_adj_cnt  == ADJ_LAST);
    assign w_scan_tick  = (r_scan_cnt == SCAN_LAST);

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_pause_d  <= 1'b0;
            r_tick_cnt <= '0;
            r_adj_cnt  <= '0;
            r_scan_cnt <= '0;
            r_dig_idx  <= 2'd0;
        end else begin
            r_pause_d  <= bus.pause;
            r_tick_cnt <= (r_state != S_RUN || w_tick) ? '0 : r_tick_cnt + TICK_W'(1);
            r_adj_cnt  <= (r_state != S_ADJUST || w_adj_tick) ? '0 : r_adj_cnt + ADJ_W'(1);
            r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + SCAN_W'(1);
            if (w_scan_tick)
                r_dig_idx <= r_dig_idx + 2'd1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_state <= S_RUN;
            r_ret   <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
        end
    end

    // sw1 outranks pause; r_ret remembers where to go back once adjust ends
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        if (bus.sw1) begin
            w_state_nxt = S_ADJUST;
            if (r_state != S_ADJUST)
                w_ret_nxt = r_state;
        end else begin
            case (r_state)
                S_RUN:    if (w_pause_edge) w_state_nxt = S_PAUSED;
                S_PAUSED: if (w_pause_edge) w_state_nxt = S_RUN;
                S_ADJUST: w_state_nxt = r_ret;
                default:  w_state_nxt = S_RUN;
            endcase
        end
    end

    assign w_zero    = (r_sec_o == 4'd0) && (r_sec_t == 4'd0) && (r_min_o == 4'd0) && (r_min_t == 4'd0);
    assign w_min_max = (r_min_t == MAX_T) && (r_min_o == MAX_O);
    assign w_sec_max = (r_sec_t == 4'd5) && (r_sec_o == 4'd9);

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_sec_o <= 4'd0;
            r_sec_t <= 4'd0;
            r_min_o <= 4'd0;
            r_min_t <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            if (!bus.dir)
                r_done <= 1'b0;
            if (w_tick && !bus.dir) begin
                if (r_sec_o != 4'd9) begin
                    r_sec_o <= r_sec_o + 4'd1;
                end else begin
                    r_sec_o <= 4'd0;
                    if (r_sec_t != 4'd5) begin
                        r_sec_t <= r_sec_t + 4'd1;
                    end else begin
                        r_sec_t <= 4'd0;
                        if (w_min_max) begin
                            r_min_o <= 4'd0;
                            r_min_t <= 4'd0;
                        end else if (r_min_o != 4'd9) begin
                            r_min_o <= r_min_o + 4'd1;
                        end else begin
                            r_min_o <= 4'd0;
                            r_min_t <= r_min_t + 4'd1;
                        end
                    end
                end
            end else if (w_tick) begin
                // Count-down holds at 00:00 and flags done instead of wrapping
                if (w_zero) begin
                    r_done <= 1'b1;
                end else begin
                    r_done <= 1'b0;
                    if (r_sec_o != 4'd0) begin
                        r_sec_o <= r_sec_o - 4'd1;
                    end else begin
                        r_sec_o <= 4'd9;
                        if (r_sec_t != 4'd0) begin
                            r_sec_t <= r_sec_t - 4'd1;
                        end else begin
                            r_sec_t <= 4'd5;
                            if (r_min_o != 4'd0) begin
                                r_min_o <= r_min_o - 4'd1;
                            end else begin
                                r_min_o <= 4'd9;
                                r_min_t <= r_min_t - 4'd1;
                            end
                        end
                    end
                end
            end else if (w_adj_tick) begin
                r_done <= 1'b0;
                if (bus.sw2) begin
                    if (w_sec_max) begin
                        r_sec_o <= 4'd0;
                        r_sec_t <= 4'd0;
                    end else if (r_sec_o != 4'd9) begin
                        r_sec_o <= r_sec_o + 4'd1;
                    end else begin
                        r_sec_o <= 4'd0;
                        r_sec_t <= r_sec_t + 4'd1;
                    end
                end else begin
                    if (w_min_max) begin
                        r_min_o <= 4'd0;
                        r_min_t <= 4'd0;
                    end else if (r_min_o != 4'd9) begin
                        r_min_o <= r_min_o + 4'd1;
                    end else begin
                        r_min_o <= 4'd0;
                        r_min_t <= r_min_t + 4'd1;
                    end
                end
            end
        end
    end

    assign w_live = {r_min_t, r_min_o, r_sec_t, r_sec_o};

`ifdef STOP_WATCH_LAP_EN
    logic        r_lap_d;
    logic        r_lap_on;
    logic [15:0] r_shadow;

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_lap_d  <= 1'b0;
            r_lap_on <= 1'b0;
            r_shadow <= 16'd0;
        end else begin
            r_lap_d <= bus.lap;
            if (bus.lap && !r_lap_d) begin
                r_lap_on <= ~r_lap_on;
                if (!r_lap_on)
                    r_shadow <= w_live;
            end
        end
    end

    assign w_disp = r_lap_on ? r_shadow : w_live;
`else
    assign w_disp = w_live;
`endif

    always_comb begin
        w_digit = w_disp[3:0];
        bus.an  = 4'b1110;
        case (r_dig_idx)
            2'd0: begin w_digit = w_disp[3:0];   bus.an = 4'b1110; end
            2'd1: begin w_digit = w_disp[7:4];   bus.an = 4'b1101; end
            2'd2: begin w_digit = w_disp[11:8];  bus.an = 4'b1011; end
            2'd3: begin w_digit = w_disp[15:12]; bus.an = 4'b0111; end
            default: ;
        endcase
    end

    assign bus.seg     = seg_decode(w_digit);
    assign bus.running = (r_state == S_RUN) && !r_done;
    assign bus.done    = r_done;
endmodule
